// File: rtl/chrono_multimode_lap.sv
// rtl/chrono_multimode_lap.sv - four-mode chronograph: timer, stopwatch with lap FIFO, time of day, daily alarm
//
// Purpose: drives an HH:MM:SS.cc display from a centisecond tick. Timer, stopwatch,
// time-of-day and alarm all run at once; the mode only chooses which one the
// buttons act on and which one is displayed.
//
// Ports:
//   clockSignal      system clock, every register on its rising edge
//   startOrStop      asynchronous active-high reset
//   btn_mode         debounced level, rising edge advances the mode
//   btn_start        debounced level, rising edge = start/stop, or alarm acknowledge
//   btn_split        debounced level, rising edge = split/reset/set
//   inputHours/Minutes/Seconds  set-point, clamped to 23/59/59
//   lap_rd           pop the lap FIFO head
//   mode             00 timer, 01 stopwatch, 10 clock, 11 alarm
//   *Display         registered h/m/s/cc of the selected source
//   lap_valid/lap_cs/lap_count  lap FIFO head and occupancy
//   ring_src         sticky ring causes: bit0 timer expired, bit1 alarm matched
//   ringSound        registered OR of ring_src
module chrono_multimode_lap #(
  parameter int TICKS_PER_CS = 1,
  parameter int LAP_DEPTH    = 8,
  parameter int CS_W         = 24,
  parameter int DAY_CS       = 8640000
) (
  input  logic                        clockSignal,
  input  logic                        startOrStop,
  input  logic                        btn_mode,
  input  logic                        btn_start,
  input  logic                        btn_split,
  input  logic [4:0]                  inputHours,
  input  logic [5:0]                  inputMinutes,
  input  logic [5:0]                  inputSeconds,
  input  logic                        lap_rd,
  output logic [1:0]                  mode,
  output logic [4:0]                  hoursDisplay,
  output logic [5:0]                  minutesDisplay,
  output logic [5:0]                  secondsDisplay,
  output logic [6:0]                  centisDisplay,
  output logic                        lap_valid,
  output logic [CS_W-1:0]             lap_cs,
  output logic [$clog2(LAP_DEPTH):0]  lap_count,
  output logic [1:0]                  ring_src,
  output logic                        ringSound
);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [CS_W-1:0] CS_MAX = CS_W'(DAY_CS - 1);

  typedef enum logic [1:0] {M_TIMER, M_STOPWATCH, M_CLOCK, M_ALARM} mode_t;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_PAUSE, T_DONE} tstate_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} sstate_t;

  mode_t     mode_q, mode_n;
  tstate_t   t_state, t_state_n;
  sstate_t   s_state, s_state_n;
  logic [CS_W-1:0] tcnt, tcnt_n, swcnt, swcnt_n, tod, tod_n, tod_inc, acs, acs_n;
  logic [CS_W-1:0] sp_cs, disp_src;
  logic            armed, armed_n;
  logic [1:0]      ring_n;
  logic            push, flush, pop, full;

  // Tick prescaler
  logic [PW-1:0] pcnt;
  logic          tick;
  assign tick = (pcnt == PW'(TICKS_PER_CS - 1));

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) pcnt <= '0;
    else if (tick)   pcnt <= '0;
    else             pcnt <= pcnt + 1'b1;
  end

  // Button edge detection
  logic btn_mode_q, btn_start_q, btn_split_q;
  logic mode_e, start_e, split_e, ack, start_go;
  assign mode_e  = btn_mode  & ~btn_mode_q;
  assign start_e = btn_start & ~btn_start_q;
  assign split_e = btn_split & ~btn_split_q;
  // A start that coincides with a split is dropped; while ringing it only acknowledges.
  assign ack      = start_e & ~split_e & ringSound;
  assign start_go = start_e & ~split_e & ~ringSound;

  // Clamped set-point in centiseconds
  logic [4:0] hrs_c;
  logic [5:0] min_c, sec_c;
  assign hrs_c = (inputHours   > 5'd23) ? 5'd23 : inputHours;
  assign min_c = (inputMinutes > 6'd59) ? 6'd59 : inputMinutes;
  assign sec_c = (inputSeconds > 6'd59) ? 6'd59 : inputSeconds;
  assign sp_cs = CS_W'(360000) * CS_W'(hrs_c) + CS_W'(6000) * CS_W'(min_c)
               + CS_W'(100) * CS_W'(sec_c);

  // Lap FIFO
  logic [CS_W-1:0] lap_mem [LAP_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  assign lap_valid = (lap_count != '0);
  assign lap_cs    = lap_mem[rd_ptr];
  assign full      = (lap_count == (AW+1)'(LAP_DEPTH));
  assign pop       = lap_rd & lap_valid;

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
    end else begin
      if (push) begin
        lap_mem[wr_ptr] <= swcnt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      // A push into a full FIFO drops the oldest entry by advancing the head.
      if (pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop && !full)  lap_count <= lap_count + 1'b1;
      else if (pop && !push)      lap_count <= lap_count - 1'b1;
    end
  end

  // Next-state logic for mode, timer, stopwatch, clock and alarm
  always_comb begin
    mode_n    = mode_q;
    t_state_n = t_state;
    tcnt_n    = tcnt;
    s_state_n = s_state;
    swcnt_n   = swcnt;
    tod_n     = tod;
    armed_n   = armed;
    acs_n     = acs;
    ring_n    = ack ? 2'b00 : ring_src;
    push      = 1'b0;
    flush     = 1'b0;
    tod_inc   = (tod == CS_MAX) ? '0 : tod + 1'b1;

    if (mode_e) mode_n = mode_t'(mode_q + 2'd1);

    if (mode_q == M_TIMER && split_e) begin
      t_state_n = T_IDLE;
      tcnt_n    = '0;
      ring_n[0] = 1'b0;
    end else begin
      if (mode_q == M_TIMER && start_go) begin
        case (t_state)
          T_IDLE: if (sp_cs != '0) begin
            t_state_n = T_RUN;
            tcnt_n    = sp_cs;
          end
          T_RUN:   t_state_n = T_PAUSE;
          T_PAUSE: t_state_n = T_RUN;
          default: t_state_n = t_state;
        endcase
      end
      if (ack && t_state == T_DONE) t_state_n = T_IDLE;
      // The tick still counts in the cycle a pause is requested; expiry wins over it.
      if (t_state == T_RUN && tick) begin
        tcnt_n = tcnt - 1'b1;
        if (tcnt == CS_W'(1)) begin
          t_state_n = T_DONE;
          ring_n[0] = 1'b1;
        end
      end
    end

    if (mode_q == M_STOPWATCH && split_e) begin
      if (s_state == S_RUN) begin
        push = 1'b1;
      end else begin
        swcnt_n   = '0;
        flush     = 1'b1;
        s_state_n = S_IDLE;
      end
    end else if (mode_q == M_STOPWATCH && start_go) begin
      s_state_n = (s_state == S_RUN) ? S_STOP : S_RUN;
    end
    if (s_state == S_RUN && tick) begin
      if (swcnt == CS_MAX) s_state_n = S_STOP;
      else                 swcnt_n   = swcnt + 1'b1;
    end

    if (mode_q == M_CLOCK && split_e) begin
      tod_n = sp_cs;
    end else if (tick) begin
      tod_n = tod_inc;
      if (armed && tod_inc == acs) ring_n[1] = 1'b1;
    end

    if (mode_q == M_ALARM && split_e) begin
      armed_n = 1'b0;
    end else if (mode_q == M_ALARM && start_go) begin
      armed_n = 1'b1;
      acs_n   = sp_cs;
    end

    case (mode_q)
      M_TIMER:     disp_src = tcnt;
      M_STOPWATCH: disp_src = swcnt;
      M_CLOCK:     disp_src = tod;
      default:     disp_src = armed ? acs : sp_cs;
    endcase
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      btn_mode_q     <= 1'b0;
      btn_start_q    <= 1'b0;
      btn_split_q    <= 1'b0;
      mode_q         <= M_TIMER;
      t_state        <= T_IDLE;
      s_state        <= S_IDLE;
      tcnt           <= '0;
      swcnt          <= '0;
      tod            <= '0;
      armed          <= 1'b0;
      acs            <= '0;
      ring_src       <= 2'b00;
      ringSound      <= 1'b0;
      hoursDisplay   <= '0;
      minutesDisplay <= '0;
      secondsDisplay <= '0;
      centisDisplay  <= '0;
    end else begin
      btn_mode_q     <= btn_mode;
      btn_start_q    <= btn_start;
      btn_split_q    <= btn_split;
      mode_q         <= mode_n;
      t_state        <= t_state_n;
      s_state        <= s_state_n;
      tcnt           <= tcnt_n;
      swcnt          <= swcnt_n;
      tod            <= tod_n;
      armed          <= armed_n;
      acs            <= acs_n;
      ring_src       <= ring_n;
      ringSound      <= |ring_src;
      hoursDisplay   <= 5'(disp_src / CS_W'(360000));
      minutesDisplay <= 6'((disp_src / CS_W'(6000)) % CS_W'(60));
      secondsDisplay <= 6'((disp_src / CS_W'(100)) % CS_W'(60));
      centisDisplay  <= (mode_q == M_ALARM) ? 7'd0 : 7'(disp_src % CS_W'(100));
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_chrono_multimode_lap.sv
// tb/tb_chrono_multimode_lap.sv - directed and random bench for chrono_multimode_lap against a behavioural model
module tb_chrono_multimode_lap;
  localparam int DAY = 8640000;
  localparam int DEPTH = 8;
  localparam int TI = 0, TR = 1, TP = 2, TD = 3;
  localparam int SI = 0, SR = 1, SS = 2;

  logic        clockSignal = 1'b0;
  logic        startOrStop;
  logic        btn_mode, btn_start, btn_split, lap_rd;
  logic [4:0]  inputHours;
  logic [5:0]  inputMinutes, inputSeconds;
  logic [1:0]  mode, ring_src;
  logic [4:0]  hoursDisplay;
  logic [5:0]  minutesDisplay, secondsDisplay;
  logic [6:0]  centisDisplay;
  logic        lap_valid, ringSound;
  logic [23:0] lap_cs;
  logic [3:0]  lap_count;

  int vectors, miscompares;

  chrono_multimode_lap #(.TICKS_PER_CS(1), .LAP_DEPTH(DEPTH), .CS_W(24), .DAY_CS(DAY)) dut (
    .clockSignal(clockSignal), .startOrStop(startOrStop),
    .btn_mode(btn_mode), .btn_start(btn_start), .btn_split(btn_split),
    .inputHours(inputHours), .inputMinutes(inputMinutes), .inputSeconds(inputSeconds),
    .lap_rd(lap_rd), .mode(mode),
    .hoursDisplay(hoursDisplay), .minutesDisplay(minutesDisplay),
    .secondsDisplay(secondsDisplay), .centisDisplay(centisDisplay),
    .lap_valid(lap_valid), .lap_cs(lap_cs), .lap_count(lap_count),
    .ring_src(ring_src), .ringSound(ringSound)
  );

  always #5 clockSignal = ~clockSignal;

  // Reference model: one update per clock with a tick every cycle.
  int m_mode, m_ts, m_tcnt, m_ss, m_sw, m_tod, m_armed, m_acs, m_ring, m_rs;
  int m_dh, m_dm, m_ds, m_dc, q_m, q_s, q_p;
  int lapq[$];

  task automatic model_reset();
    m_mode = 0; m_ts = TI; m_tcnt = 0; m_ss = SI; m_sw = 0; m_tod = 0;
    m_armed = 0; m_acs = 0; m_ring = 0; m_rs = 0;
    m_dh = 0; m_dm = 0; m_ds = 0; m_dc = 0; q_m = 0; q_s = 0; q_p = 0;
    lapq.delete();
  endtask

  task automatic model_tick();
    int me, se, pe, ack, go, h, mi, s, sp, src, rem, nr, old_ts, old_ss;
    me = (btn_mode  && !q_m) ? 1 : 0;
    se = (btn_start && !q_s) ? 1 : 0;
    pe = (btn_split && !q_p) ? 1 : 0;
    q_m = int'(btn_mode); q_s = int'(btn_start); q_p = int'(btn_split);
    h  = (inputHours   > 23) ? 23 : int'(inputHours);
    mi = (inputMinutes > 59) ? 59 : int'(inputMinutes);
    s  = (inputSeconds > 59) ? 59 : int'(inputSeconds);
    sp = h * 3600 * 100 + mi * 60 * 100 + s * 100;
    ack = (se && !pe && m_rs) ? 1 : 0;
    go  = (se && !pe && !m_rs) ? 1 : 0;

    case (m_mode)
      0: src = m_tcnt;
      1: src = m_sw;
      2: src = m_tod;
      default: src = m_armed ? m_acs : sp;
    endcase
    m_dh = src / 360000; rem = src % 360000;
    m_dm = rem / 6000;   rem = rem % 6000;
    m_ds = rem / 100;
    m_dc = (m_mode == 3) ? 0 : rem % 100;

    nr = ack ? 0 : m_ring;

    old_ts = m_ts;
    if (m_mode == 0 && pe) begin
      m_ts = TI; m_tcnt = 0; nr = nr & 2;
    end else begin
      if (m_mode == 0 && go) begin
        if (old_ts == TI && sp > 0) begin m_ts = TR; m_tcnt = sp; end
        else if (old_ts == TR) m_ts = TP;
        else if (old_ts == TP) m_ts = TR;
      end
      if (ack && old_ts == TD) m_ts = TI;
      if (old_ts == TR) begin
        m_tcnt = m_tcnt - 1;
        if (m_tcnt == 0) begin m_ts = TD; nr = nr | 1; end
      end
    end

    old_ss = m_ss;
    if (m_mode == 1 && pe && old_ss != SR) begin
      m_sw = 0; lapq.delete(); m_ss = SI;
    end else begin
      if (lap_rd && lapq.size() > 0) void'(lapq.pop_front());
      if (m_mode == 1 && pe) begin
        lapq.push_back(m_sw);
        if (lapq.size() > DEPTH) void'(lapq.pop_front());
      end else if (m_mode == 1 && go) begin
        m_ss = (old_ss == SR) ? SS : SR;
      end
    end
    if (old_ss == SR) begin
      if (m_sw == DAY - 1) m_ss = SS;
      else m_sw = m_sw + 1;
    end

    if (m_mode == 2 && pe) m_tod = sp;
    else begin
      m_tod = (m_tod + 1) % DAY;
      if (m_armed && m_tod == m_acs) nr = nr | 2;
    end

    if (m_mode == 3 && pe) m_armed = 0;
    else if (m_mode == 3 && go) begin m_armed = 1; m_acs = sp; end

    if (me) m_mode = (m_mode + 1) % 4;
    m_rs = (m_ring != 0) ? 1 : 0;
    m_ring = nr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mode", 32'(mode), m_mode);
    chk("hours", 32'(hoursDisplay), m_dh);
    chk("minutes", 32'(minutesDisplay), m_dm);
    chk("seconds", 32'(secondsDisplay), m_ds);
    chk("centis", 32'(centisDisplay), m_dc);
    chk("lap_valid", 32'(lap_valid), (lapq.size() != 0) ? 1 : 0);
    chk("lap_count", 32'(lap_count), lapq.size());
    if (lapq.size() != 0) chk("lap_cs", 32'(lap_cs), lapq[0]);
    chk("ring_src", 32'(ring_src), m_ring);
    chk("ringSound", 32'(ringSound), m_rs);
  endtask

  task automatic step();
    @(posedge clockSignal);
    model_tick();
    @(negedge clockSignal);
    check_all();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    inputHours = 5'(h); inputMinutes = 6'(m); inputSeconds = 6'(s);
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(); btn_start = 1'b0;
  endtask

  task automatic press_split();
    btn_split = 1'b1; step(); btn_split = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    btn_mode = 0; btn_start = 0; btn_split = 0; lap_rd = 0;
    set_time(0, 0, 0);
    startOrStop = 1'b1;
    model_reset();
    repeat (2) @(negedge clockSignal);
    check_all();
    startOrStop = 1'b0;

    // Reset while the timer is counting
    set_time(0, 0, 5);
    press_start();
    step();
    chk("t1_pre_seconds", 32'(secondsDisplay), 5);
    #2 startOrStop = 1'b1;
    model_reset();
    #1;
    chk("t1_rst_seconds", 32'(secondsDisplay), 0);
    chk("t1_rst_mode", 32'(mode), 0);
    chk("t1_rst_count", 32'(lap_count), 0);
    check_all();
    @(negedge clockSignal);
    startOrStop = 1'b0;

    // Timer 0:0:3 expiry and acknowledge
    set_time(0, 0, 3);
    press_start();
    repeat (299) step();
    chk("t2_ring_early", 32'(ring_src), 0);
    step();
    chk("t2_ring", 32'(ring_src), 1);
    step();
    chk("t2_sound", 32'(ringSound), 1);
    press_start();
    chk("t2_ack_ring", 32'(ring_src), 0);
    step();
    chk("t2_ack_sound", 32'(ringSound), 0);

    // Timer pause and resume
    press_start();
    repeat (49) step();
    press_start();
    repeat (20) step();
    press_start();
    chk("t3_resume_s", 32'(secondsDisplay), 2);
    chk("t3_resume_cc", 32'(centisDisplay), 50);
    repeat (249) step();
    chk("t3_ring_early", 32'(ring_src), 0);
    step();
    chk("t3_ring", 32'(ring_src), 1);
    step();
    press_start();

    // Stopwatch laps with FIFO overflow
    press_mode();
    press_start();
    repeat (100) step();
    press_split();
    for (int k = 2; k <= 10; k++) begin
      repeat (99) step();
      press_split();
    end
    chk("t4_count", 32'(lap_count), 8);
    lap_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_pop", 32'(lap_cs), 300 + 100 * i);
      step();
    end
    lap_rd = 1'b0;
    chk("t4_empty", 32'(lap_valid), 0);

    // Same-cycle start and split while running
    btn_start = 1'b1; btn_split = 1'b1;
    step();
    btn_start = 1'b0; btn_split = 1'b0;
    chk("t6_count", 32'(lap_count), 1);
    repeat (5) step();

    // Clock set and midnight wrap
    press_mode();
    set_time(23, 59, 59);
    press_split();
    step();
    chk("t5_h", 32'(hoursDisplay), 23);
    chk("t5_cc", 32'(centisDisplay), 0);
    repeat (100) step();
    chk("t5_wrap_h", 32'(hoursDisplay), 0);
    chk("t5_wrap_m", 32'(minutesDisplay), 0);
    chk("t5_wrap_s", 32'(secondsDisplay), 0);
    chk("t5_wrap_cc", 32'(centisDisplay), 0);

    // Alarm match, acknowledge, clamp display
    set_time(0, 0, 4);
    press_mode();
    press_start();
    for (int i = 0; i < 600 && ring_src[1] !== 1'b1; i++) step();
    chk("alarm_ring", 32'(ring_src[1]), 1);
    step();
    press_start();
    press_split();
    set_time(31, 63, 0);
    step();
    chk("clamp_h", 32'(hoursDisplay), 23);
    chk("clamp_m", 32'(minutesDisplay), 59);

    // Random stimulus
    for (int n = 0; n < 4000; n++) begin
      btn_mode  = ($urandom_range(0, 99) < 3);
      btn_start = ($urandom_range(0, 99) < 10);
      btn_split = ($urandom_range(0, 99) < 7);
      lap_rd    = ($urandom_range(0, 99) < 15);
      inputHours   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      inputMinutes = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      inputSeconds = 6'($urandom_range(0, 8));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
